// File: rtl/linear_pkg.sv
// Shared constants and helpers for the fully-connected layer engine:
// FSM encodings, Q-format unit value, index-width helper and the output clamp.
package linear_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_MAC  = 2'd2;
   localparam logic [1:0] S_EMIT = 2'd3;

   localparam int          DEF_FRAC_W = 24;
   localparam logic [63:0] Q_ONE      = 64'd1 << DEF_FRAC_W;

   // Width needed to index n items, never less than one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   // ReLU (when enabled) takes precedence; otherwise clamp to the signed data_w range.
   function automatic logic [127:0] sat_relu(input logic signed [127:0] acc,
                                             input int data_w,
                                             input logic relu,
                                             output logic clamped);
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      logic signed [127:0] res;
      hi      = (128'sd1 <<< (data_w - 1)) - 128'sd1;
      lo      = -(128'sd1 <<< (data_w - 1));
      clamped = 1'b0;
      res     = acc;
      if (relu && acc < 128'sd0) begin
         res = 128'sd0;
      end else if (acc > hi) begin
         res     = hi;
         clamped = 1'b1;
      end else if (acc < lo) begin
         res     = lo;
         clamped = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Fixed-point multiply-accumulate datapath: floor-shifted products and
// unshifted bias are added into a registered accumulator.
module mac_unit #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 24,
   parameter int ACC_W  = 48
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     mul_en,
   input  logic                     bias_en,
   input  logic signed [DATA_W-1:0] w,
   input  logic signed [DATA_W-1:0] x,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [2*DATA_W-1:0] prod_sh;
   logic signed [ACC_W-1:0]    term;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    acc_reg;

   assign prod     = (2*DATA_W)'(w) * (2*DATA_W)'(x);
   assign prod_sh  = prod >>> FRAC_W;
   // Signed size casts sign-extend or truncate to the accumulator width.
   assign term     = ACC_W'(prod_sh);
   assign bias_ext = ACC_W'(w);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
      end else if (clear) begin
         acc_reg <= '0;
      end else if (bias_en) begin
         acc_reg <= acc_reg + bias_ext;
      end else if (mul_en) begin
         acc_reg <= acc_reg + term;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/linear_layer_mac.sv
// Fully-connected layer engine: buffers an input vector, streams weights from
// an external synchronous memory and emits act(W*x + b) one neuron at a time.
module linear_layer_mac
   import linear_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int FRAC_W  = 24,
   parameter int ACC_W   = 48,
   parameter int IN_DIM  = 20,
   parameter int OUT_DIM = 32,
   parameter int WADDR_W = 10
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              relu_en,
   input  logic [DATA_W-1:0]                 in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic                              w_rd_en,
   output logic [WADDR_W-1:0]                w_addr,
   input  logic [DATA_W-1:0]                 w_data,
   output logic [DATA_W-1:0]                 out_data,
   output logic [clog2_min1(OUT_DIM)-1:0]    out_idx,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              busy,
   output logic                              done,
   output logic                              sat_flag
);

   localparam int IDX_W = clog2_min1(OUT_DIM);
   localparam int K_W   = clog2_min1(IN_DIM + 2);
   localparam int BUF_N = 2 ** K_W;

   logic [1:0]               state_reg;
   logic                     relu_reg;
   logic                     busy_reg;
   logic                     done_reg;
   logic                     sat_reg;
   logic [K_W-1:0]           k_reg;
   logic [IDX_W-1:0]         row_reg;
   logic [WADDR_W-1:0]       addr_reg;
   logic [DATA_W-1:0]        buf_mem [BUF_N];
   logic signed [DATA_W-1:0] x_rd_reg;

   logic                     mac_clear;
   logic                     mac_mul;
   logic                     mac_bias;
   logic signed [ACC_W-1:0]  acc;
   logic signed [127:0]      acc_wide;
   logic [127:0]             sat_word;
   logic                     sat_hit;

   // k_reg counts LOAD beats, then MAC cycles 0..IN_DIM+1 within a row.
   assign in_ready  = (state_reg == S_LOAD);
   assign w_rd_en   = (state_reg == S_MAC) && (k_reg <= K_W'(IN_DIM));
   assign w_addr    = w_rd_en ? addr_reg : '0;
   assign mac_clear = (state_reg == S_MAC) && (k_reg == '0);
   assign mac_mul   = (state_reg == S_MAC) && (k_reg != '0) && (k_reg <= K_W'(IN_DIM));
   assign mac_bias  = (state_reg == S_MAC) && (k_reg == K_W'(IN_DIM + 1));

   mac_unit #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (mac_clear),
      .mul_en  (mac_mul),
      .bias_en (mac_bias),
      .w       (w_data),
      .x       (x_rd_reg),
      .acc     (acc)
   );

   assign acc_wide = {{(128 - ACC_W){acc[ACC_W-1]}}, acc};

   always_comb begin
      sat_hit  = 1'b0;
      sat_word = sat_relu(acc_wide, DATA_W, relu_reg, sat_hit);
   end

   assign out_valid = (state_reg == S_EMIT);
   assign out_data  = out_valid ? DATA_W'(sat_word) : '0;
   assign out_idx   = out_valid ? row_reg : '0;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign sat_flag  = sat_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         relu_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         sat_reg   <= 1'b0;
         k_reg     <= '0;
         row_reg   <= '0;
         addr_reg  <= '0;
         x_rd_reg  <= '0;
         for (int i = 0; i < BUF_N; i++) buf_mem[i] <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  relu_reg  <= relu_en;
                  sat_reg   <= 1'b0;
                  busy_reg  <= 1'b1;
                  k_reg     <= '0;
                  row_reg   <= '0;
                  addr_reg  <= '0;
                  state_reg <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  buf_mem[k_reg] <= in_data;
                  if (k_reg == K_W'(IN_DIM - 1)) begin
                     k_reg     <= '0;
                     state_reg <= S_MAC;
                  end else begin
                     k_reg <= k_reg + 1'b1;
                  end
               end
            end
            S_MAC: begin
               // Registered buffer read lines up with the weight returning next cycle.
               if (k_reg < K_W'(IN_DIM)) x_rd_reg <= buf_mem[k_reg];
               if (w_rd_en) addr_reg <= addr_reg + 1'b1;
               if (k_reg == K_W'(IN_DIM + 1)) begin
                  k_reg     <= '0;
                  state_reg <= S_EMIT;
               end else begin
                  k_reg <= k_reg + 1'b1;
               end
            end
            S_EMIT: begin
               if (sat_hit) sat_reg <= 1'b1;
               if (out_ready) begin
                  if (row_reg == IDX_W'(OUT_DIM - 1)) begin
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                     state_reg <= S_IDLE;
                  end else begin
                     row_reg   <= row_reg + 1'b1;
                     state_reg <= S_MAC;
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_linear_layer_mac.sv
// Directed bench for linear_layer_mac with IN_DIM=4, OUT_DIM=2 and a
// synchronous weight memory model.
module tb_linear_layer_mac;
   import linear_pkg::*;

   localparam int IN_DIM  = 4;
   localparam int OUT_DIM = 2;
   localparam int WADDR_W = 10;
   localparam logic [31:0] ONE = Q_ONE[31:0];

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                relu_en = 1'b0;
   logic [31:0]         in_data = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic                w_rd_en;
   logic [WADDR_W-1:0]  w_addr;
   logic [31:0]         w_data = '0;
   logic [31:0]         out_data;
   logic [0:0]          out_idx;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic                busy;
   logic                done;
   logic                sat_flag;

   logic [31:0] wmem [1024];
   logic [31:0] xcur [4];
   int checks = 0;
   int passed = 0;
   int wt;

   linear_layer_mac #(
      .DATA_W (32), .FRAC_W (24), .ACC_W (48),
      .IN_DIM (IN_DIM), .OUT_DIM (OUT_DIM), .WADDR_W (WADDR_W)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .relu_en (relu_en),
      .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
      .w_rd_en (w_rd_en), .w_addr (w_addr), .w_data (w_data),
      .out_data (out_data), .out_idx (out_idx), .out_valid (out_valid),
      .out_ready (out_ready), .busy (busy), .done (done), .sat_flag (sat_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (w_rd_en) w_data <= wmem[w_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_mem(input logic [31:0] w0, input logic [31:0] b0, input logic [31:0] w1a,
                          input logic [31:0] w1, input logic [31:0] b1);
      for (int k = 0; k < 4; k++) wmem[k] = w0;
      wmem[4] = b0;
      wmem[5] = w1a;
      for (int k = 6; k < 9; k++) wmem[k] = w1;
      wmem[9] = b1;
   endtask

   // Entered and left just after a falling edge.
   task automatic pulse_start(input logic relu);
      start = 1'b1;
      relu_en = relu;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_vec(input bit gap);
      int w;
      for (int k = 0; k < IN_DIM; k++) begin
         if (gap) begin
            in_valid = 1'b0;
            if (k == 1) begin
               start = 1'b1;
               relu_en = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
         end
         in_valid = 1'b1;
         in_data = xcur[k];
         w = 0;
         while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
         end
         chk("load_in_ready", 32'(in_ready), 32'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data = '0;
   endtask

   task automatic do_run(input string tag, input logic relu, input bit gap, input int stall,
                         input bit chk_addr, input logic [31:0] exp0, input logic [31:0] exp1,
                         input logic exp_sat);
      int nrd, nd, got, held, cyc;
      logic [31:0] res [2];
      logic [0:0] ridx [2];
      logic [31:0] hold_data;
      logic [WADDR_W-1:0] alog [16];
      int clog [16];
      nrd = 0; nd = 0; got = 0; held = 0; cyc = 0; hold_data = '0;
      pulse_start(relu);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      load_vec(gap);
      out_ready = (stall == 0);
      while (nd == 0 && cyc < 400) begin
         if (w_rd_en) begin
            if (nrd < 16) begin
               alog[nrd] = w_addr;
               clog[nrd] = cyc;
            end
            nrd++;
         end
         if (done) nd++;
         if (out_valid) begin
            if (!out_ready) begin
               if (held == 0) hold_data = out_data;
               else chk({tag, "_stall_data"}, out_data, hold_data);
               chk({tag, "_stall_rd_en"}, 32'(w_rd_en), 32'd0);
               chk({tag, "_stall_valid"}, 32'(out_idx), 32'd0);
               held++;
               if (held >= stall) out_ready = 1'b1;
            end
            if (out_ready && got < 2) begin
               res[got] = out_data;
               ridx[got] = out_idx;
               got++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_done_seen"}, 32'(nd), 32'd1);
      chk({tag, "_n_results"}, 32'(got), 32'd2);
      chk({tag, "_y0"}, res[0], exp0);
      chk({tag, "_idx0"}, 32'(ridx[0]), 32'd0);
      chk({tag, "_y1"}, res[1], exp1);
      chk({tag, "_idx1"}, 32'(ridx[1]), 32'd1);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_sat"}, 32'(sat_flag), 32'(exp_sat));
      if (stall > 0) chk({tag, "_stall_cycles"}, 32'(held), 32'(stall));
      if (chk_addr) begin
         chk({tag, "_n_reads"}, 32'(nrd), 32'd10);
         for (int i = 0; i < 10; i++) chk({tag, "_w_addr"}, 32'(alog[i]), 32'(i));
         for (int i = 1; i < 10; i++)
            if (i != 5) chk({tag, "_rd_gap"}, 32'(clog[i]), 32'(clog[i-1] + 1));
      end
   endtask

   initial begin
      xcur[0] = 32'h01000000;   //  1.0
      xcur[1] = 32'h02000000;   //  2.0
      xcur[2] = 32'hFF000000;   // -1.0
      xcur[3] = 32'h00800000;   //  0.5

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sat", 32'(sat_flag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_w_rd_en", 32'(w_rd_en), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic layer, then ReLU variant
      set_mem(ONE, 32'h0, 32'h00800000, 32'h0, 32'hFF000000);
      do_run("basic", 1'b0, 1'b0, 0, 1'b1, 32'h02800000, 32'hFF800000, 1'b0);
      do_run("relu", 1'b1, 1'b0, 0, 1'b0, 32'h02800000, 32'h00000000, 1'b0);

      // Saturation both directions
      for (int k = 0; k < 4; k++) xcur[k] = 32'h7F000000;
      set_mem(32'h7F000000, 32'h0, 32'h81000000, 32'h81000000, 32'h0);
      do_run("sat", 1'b0, 1'b0, 0, 1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b1);

      // Back-pressure on row0; start of this run must also clear sat_flag
      xcur[0] = 32'h01000000; xcur[1] = 32'h02000000; xcur[2] = 32'hFF000000; xcur[3] = 32'h00800000;
      set_mem(ONE, 32'h0, 32'h00800000, 32'h0, 32'hFF000000);
      do_run("stall", 1'b0, 1'b0, 10, 1'b1, 32'h02800000, 32'hFF800000, 1'b0);

      // Gapped input stream with a stray start (relu_en=1) during LOAD
      do_run("gap", 1'b0, 1'b1, 0, 1'b0, 32'h02800000, 32'hFF800000, 1'b0);
      relu_en = 1'b0;

      // Reset in the middle of row1 of a saturating run
      for (int k = 0; k < 4; k++) xcur[k] = 32'h7F000000;
      set_mem(32'h7F000000, 32'h0, 32'h81000000, 32'h81000000, 32'h0);
      pulse_start(1'b0);
      load_vec(1'b0);
      out_ready = 1'b1;
      wt = 0;
      while (!(w_rd_en && w_addr == 10'd6) && wt < 200) begin
         @(negedge clk);
         wt++;
      end
      chk("mid_w_addr", 32'(w_addr), 32'd6);
      chk("mid_sat", 32'(sat_flag), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_data", out_data, 32'd0);
      chk("arst_out_idx", 32'(out_idx), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_sat", 32'(sat_flag), 32'd0);
      chk("arst_w_rd_en", 32'(w_rd_en), 32'd0);
      chk("arst_w_addr", 32'(w_addr), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("arst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fresh run after reset
      xcur[0] = 32'h01000000; xcur[1] = 32'h02000000; xcur[2] = 32'hFF000000; xcur[3] = 32'h00800000;
      set_mem(ONE, 32'h0, 32'h00800000, 32'h0, 32'hFF000000);
      do_run("fresh", 1'b0, 1'b0, 0, 1'b1, 32'h02800000, 32'hFF800000, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/linear_layer_mac.md
Name: linear_layer_mac

Overview:
Parametrised fully-connected layer engine for the KWS inference datapath. It computes y = act(W·x + b) for an IN_DIM input vector and OUT_DIM outputs in signed fixed point Q(DATA_W-FRAC_W).FRAC_W. Inputs arrive on a valid/ready stream and are buffered locally. Weights and biases come from an external synchronous weight memory. Results leave on a valid/ready stream with back-pressure, between the feature extractor and the classifier stage.

Parameters:
DATA_W, 32, operand/result width (signed)
FRAC_W, 24, fractional bits (default Q8.24)
ACC_W, 48, accumulator width (guard bits above DATA_W)
IN_DIM, 20, input vector length (>=1)
OUT_DIM, 32, number of output neurons (>=1)
WADDR_W, 10, weight memory address width; must hold OUT_DIM*(IN_DIM+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begins a run; ignored unless IDLE
relu_en  in  1  sampled on start; 1 = clamp negative results to 0
in_data  in  DATA_W  input vector element
in_valid  in  1  in_data valid
in_ready  out  1  high only in LOAD
w_rd_en  out  1  weight memory read strobe
w_addr  out  WADDR_W  weight memory address
w_data  in  DATA_W  weight/bias, valid 1 cycle after w_rd_en
out_data  out  DATA_W  result y[out_idx]
out_idx  out  clog2(OUT_DIM)  output neuron index
out_valid  out  1  result valid
out_ready  in  1  downstream accept
busy  out  1  high from start accept until done
done  out  1  one-cycle pulse after last output accepted
sat_flag  out  1  sticky per run: any result saturated

Behaviour:
- Reset: all outputs 0, state IDLE, buffers and accumulator cleared. Reset mid-run aborts immediately, with no partial output.
- Memory layout: row r occupies addresses r*(IN_DIM+1) .. r*(IN_DIM+1)+IN_DIM-1 for weights, and r*(IN_DIM+1)+IN_DIM for the bias.
- IDLE: on start, latch relu_en, clear sat_flag, busy<=1, go LOAD.
- LOAD: in_ready=1. Each in_valid&in_ready beat writes buffer[k], k++. Gaps in in_valid are allowed. After the IN_DIM-th beat go MAC with row=0.
- MAC: issue w_rd_en for IN_DIM weight addresses on consecutive cycles, then the bias address. Each returned weight (1 cycle later) is multiplied with buffer[k].
  - Product is 2*DATA_W signed, arithmetically shifted right by FRAC_W (floor), sign-extended to ACC_W, and accumulated.
  - The bias is sign-extended and added unshifted.
  - Accumulator clears at row start.
  - Row latency is IN_DIM+2 cycles from first w_rd_en to EMIT.
- EMIT:
  - If relu_en and acc<0, the result is 0.
  - Otherwise the result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat_flag<=1 if clamped.
  - Assert out_valid with out_idx=row. out_data and out_idx are held stable while out_ready=0.
  - On handshake: if row<OUT_DIM-1, row++ and return to MAC. Otherwise pulse done, busy<=0, go IDLE.
- No weight reads are issued during EMIT stall; the input buffer is retained across rows.
- start while busy is ignored. in_valid outside LOAD is ignored (in_ready=0).
- IN_DIM=1 and OUT_DIM=1 are legal. Counters must not wrap past DIM-1.
- w_addr is computed incrementally (running pointer), with no multiplier.

Decomposition:
- Package linear_pkg: state enum (IDLE, LOAD, MAC, EMIT), Q-format constants (Q_ONE = 1<<FRAC_W), saturate/relu function, clog2 helper.
- Sub-module mac_unit: multiply, shift, accumulate with clear/bias-add controls; pure datapath with 1-cycle registered accumulate.

Test Plan:
- IN_DIM=4, OUT_DIM=2, x=[1.0,2.0,-1.0,0.5]. Row0 w=all 1.0, b=0 -> out_idx0 = 0x02800000. Row1 w=[0.5,0,0,0], b=-1.0 -> out_idx1 = 0xFF800000 (relu_en=0) or 0x00000000 (relu_en=1). done pulses once.
- Saturation: x=all 127.0, w=all 127.0 -> out_data=0x7FFFFFFF, sat_flag=1. Negated weights -> 0x80000000.
- Back-pressure: hold out_ready=0 for 10 cycles on row0 -> out_valid stays 1, out_data stable, w_rd_en=0 throughout, and the row1 result is still correct.
- LOAD with in_valid toggling every other cycle -> buffer is correct and the results match the first scenario. A start pulse during busy causes no restart.
- Assert rst_n low mid-MAC of row1 -> all outputs are 0 next cycle. A fresh run then produces correct results and sat_flag is cleared.
- w_addr sequence check for OUT_DIM=2, IN_DIM=4 -> 0..4, then 5..9, one read per cycle in MAC.
